// File: rtl/vga_circle_gen.sv
// rtl/vga_circle_gen.sv - pipelined disc/ring renderer with bouncing centre
// Optional VGA_CIRCLE_BOUNCE_COLOR_EN: foreground colour cycles through a 4-entry palette on each bounce.
module vga_circle_gen #(
   parameter int          COORD_W  = 10,
   parameter int          H_ACT    = 640,
   parameter int          V_ACT    = 480,
   parameter int          RADIUS   = 100,
   parameter int          RING_W   = 4,
   parameter int          STEP     = 2,
   parameter logic [15:0] FG_COLOR = 16'hCF59,
   parameter logic [15:0] BG_COLOR = 16'h0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic               move_en,
   input  logic               ring_mode,
   output logic [15:0]        pix_data,
   output logic [COORD_W-1:0] cx,
   output logic [COORD_W-1:0] cy
);

   localparam int SQW = 2 * (COORD_W + 1);
   localparam int D2W = SQW + 1;

   localparam logic [D2W-1:0]     C_R2_OUT = D2W'(RADIUS * RADIUS);
   localparam logic [D2W-1:0]     C_R2_IN  = D2W'((RADIUS - RING_W) * (RADIUS - RING_W));
   localparam logic [COORD_W-1:0] C_STEP   = COORD_W'(STEP);
   localparam logic [COORD_W-1:0] C_XMAX   = COORD_W'(H_ACT - 1 - RADIUS);
   localparam logic [COORD_W-1:0] C_YMAX   = COORD_W'(V_ACT - 1 - RADIUS);
   localparam logic [COORD_W-1:0] C_MIN_S  = COORD_W'(RADIUS + STEP);
   localparam logic [COORD_W-1:0] C_FE_X   = COORD_W'(H_ACT - 1);
   localparam logic [COORD_W-1:0] C_FE_Y   = COORD_W'(V_ACT - 1);
   localparam logic [COORD_W-1:0] C_CX_RST = COORD_W'(H_ACT / 2);
   localparam logic [COORD_W-1:0] C_CY_RST = COORD_W'(V_ACT / 2);

   localparam logic [0:0] DIR_NEG = 1'b0;
   localparam logic [0:0] DIR_POS = 1'b1;

   logic [COORD_W-1:0] r_cx, r_cy;
   logic [0:0]         r_dir_x, r_dir_y;
   logic [SQW-1:0]     r_dx2, r_dy2;
   logic               r_vld, r_ring;
   logic [15:0]        r_pix;

   logic signed [COORD_W:0] w_dx, w_dy;
   logic signed [SQW-1:0]   w_dx_ext, w_dy_ext;
   logic [SQW-1:0]          w_dx2, w_dy2;
   logic [D2W-1:0]          w_d2;
   logic                    w_hit, w_fe, w_upd;
   logic [COORD_W-1:0]      w_cx_nxt, w_cy_nxt;
   logic [0:0]              w_dir_x_nxt, w_dir_y_nxt;
   logic                    w_rev_x, w_rev_y;
   logic [15:0]             w_fg;

   // Zero-extend before subtracting so the extra bit carries the sign of the offset.
   assign w_dx     = $signed({1'b0, pix_x}) - $signed({1'b0, r_cx});
   assign w_dy     = $signed({1'b0, pix_y}) - $signed({1'b0, r_cy});
   assign w_dx_ext = {{(COORD_W + 1){w_dx[COORD_W]}}, w_dx};
   assign w_dy_ext = {{(COORD_W + 1){w_dy[COORD_W]}}, w_dy};
   assign w_dx2    = w_dx_ext * w_dx_ext;
   assign w_dy2    = w_dy_ext * w_dy_ext;

   assign w_d2  = {1'b0, r_dx2} + {1'b0, r_dy2};
   assign w_hit = (w_d2 <= C_R2_OUT) && (!r_ring || (w_d2 >= C_R2_IN));

   assign w_fe  = (pix_x == C_FE_X) && (pix_y == C_FE_Y);
   assign w_upd = w_fe && move_en;

   always_comb begin
      w_cx_nxt    = r_cx;
      w_dir_x_nxt = r_dir_x;
      w_rev_x     = 1'b0;
      if (r_dir_x == DIR_POS) begin
         if (r_cx + C_STEP <= C_XMAX) begin
            w_cx_nxt = r_cx + C_STEP;
         end else begin
            w_cx_nxt    = r_cx - C_STEP;
            w_dir_x_nxt = DIR_NEG;
            w_rev_x     = 1'b1;
         end
      end else begin
         if (r_cx >= C_MIN_S) begin
            w_cx_nxt = r_cx - C_STEP;
         end else begin
            w_cx_nxt    = r_cx + C_STEP;
            w_dir_x_nxt = DIR_POS;
            w_rev_x     = 1'b1;
         end
      end
   end

   always_comb begin
      w_cy_nxt    = r_cy;
      w_dir_y_nxt = r_dir_y;
      w_rev_y     = 1'b0;
      if (r_dir_y == DIR_POS) begin
         if (r_cy + C_STEP <= C_YMAX) begin
            w_cy_nxt = r_cy + C_STEP;
         end else begin
            w_cy_nxt    = r_cy - C_STEP;
            w_dir_y_nxt = DIR_NEG;
            w_rev_y     = 1'b1;
         end
      end else begin
         if (r_cy >= C_MIN_S) begin
            w_cy_nxt = r_cy - C_STEP;
         end else begin
            w_cy_nxt    = r_cy + C_STEP;
            w_dir_y_nxt = DIR_POS;
            w_rev_y     = 1'b1;
         end
      end
   end

`ifdef VGA_CIRCLE_BOUNCE_COLOR_EN
   logic [1:0] r_pal;

   // A corner bounce reverses both axes but still advances the palette only once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pal <= 2'd0;
      end else if (w_upd && (w_rev_x || w_rev_y)) begin
         r_pal <= r_pal + 2'd1;
      end
   end

   always_comb begin
      case (r_pal)
         2'd0:    w_fg = FG_COLOR;
         2'd1:    w_fg = 16'hF800;
         2'd2:    w_fg = 16'h07E0;
         default: w_fg = 16'h001F;
      endcase
   end
`else
   assign w_fg = FG_COLOR;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cx    <= C_CX_RST;
         r_cy    <= C_CY_RST;
         r_dir_x <= DIR_POS;
         r_dir_y <= DIR_POS;
      end else if (w_upd) begin
         r_cx    <= w_cx_nxt;
         r_cy    <= w_cy_nxt;
         r_dir_x <= w_dir_x_nxt;
         r_dir_y <= w_dir_y_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dx2  <= '0;
         r_dy2  <= '0;
         r_vld  <= 1'b0;
         r_ring <= 1'b0;
         r_pix  <= 16'h0000;
      end else begin
         r_dx2  <= w_dx2;
         r_dy2  <= w_dy2;
         r_vld  <= (pix_x != '1) && (pix_y != '1);
         r_ring <= ring_mode;
         r_pix  <= (r_vld && w_hit) ? w_fg : BG_COLOR;
      end
   end

   assign pix_data = r_pix;
   assign cx       = r_cx;
   assign cy       = r_cy;

endmodule
